// File: rtl/shift_des_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Package    : shift_des_pkg                                              |
// | Description: Shared types, defaults and helpers for shift_deserializer. |
// | Revision   : 1.0 - initial release                                      |
// +-------------------------------------------------------------------------+
package shift_des_pkg;

  // Receiver FSM states; PARITY is only reachable in parity builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter width able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_des_outbuf.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module     : shift_des_outbuf                                           |
// | Description: Single-entry valid/ready word buffer. Decides whether a    |
// |              completed frame is loaded or dropped, and raises the       |
// |              sticky overrun flag when a frame is dropped.               |
// | Revision   : 1.0 - initial release                                      |
// +-------------------------------------------------------------------------+
module shift_des_outbuf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_done,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_perr,
  input  logic             i_ready,
  input  logic             i_clear_err,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_perr,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_perr;
  logic             r_overrun;

  logic w_drain;
  logic w_load;
  logic w_drop;

  // A held word leaving this cycle frees the slot for a same-cycle completion.
  assign w_drain = r_valid & i_ready;
  assign w_load  = i_done & (~r_valid | w_drain);
  assign w_drop  = i_done & r_valid & ~i_ready;

  // Holding register: load on completion, clear valid on drain, keep data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_load) begin
      r_word  <= i_word;
      r_valid <= 1'b1;
      r_perr  <= i_perr;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun; a fresh drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_clear_err) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_perr    = r_perr;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module     : shift_deserializer                                         |
// | Description: Serial-to-parallel receiver, LSB- or MSB-first per frame,  |
// |              with a single-entry valid/ready output buffer.             |
// | Config     : SHIFT_DES_PARITY_EN - adds one even-parity bit per frame   |
// |              and drives word_perr; otherwise word_perr is tied 0.       |
// | Revision   : 1.0 - initial release                                      |
// +-------------------------------------------------------------------------+
module shift_deserializer
  import shift_des_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             lsb_first,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_perr,
  output logic             busy,
  output logic             overrun,
  input  logic             clear_err
);

  localparam int          c_CW   = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
`ifdef SHIFT_DES_PARITY_EN
  localparam bit          c_PAR_EN = 1'b1;
`else
  localparam bit          c_PAR_EN = 1'b0;
`endif

  state_t            r_state,  w_state_nxt;
  logic [WIDTH-1:0]  r_sr,     w_sr_nxt;
  logic [c_CW-1:0]   r_cnt,    w_cnt_nxt;
  logic              r_lsb,    w_lsb_nxt;
  logic              r_par,    w_par_nxt;

  logic [WIDTH-1:0]  w_shifted;
  logic              w_done;
  logic [WIDTH-1:0]  w_word;
  logic              w_perr;

  // Shift register contents once the current bit is absorbed.
  assign w_shifted = r_lsb ? {bit_in, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], bit_in};

  // Next-state logic; frame_start restarts from any state and eats the bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_lsb_nxt   = r_lsb;
    w_par_nxt   = r_par;
    w_done      = 1'b0;
    w_word      = r_sr;
    w_perr      = 1'b0;
    if (frame_start) begin
      w_state_nxt = SHIFT;
      w_sr_nxt    = '0;
      w_cnt_nxt   = '0;
      w_lsb_nxt   = lsb_first;
      w_par_nxt   = 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          if (bit_valid) begin
            w_sr_nxt  = w_shifted;
            w_cnt_nxt = r_cnt + c_CW'(1);
            w_par_nxt = r_par ^ bit_in;
            if (r_cnt == c_LAST) begin
              if (c_PAR_EN) begin
                w_state_nxt = PARITY;
              end else begin
                w_state_nxt = IDLE;
                w_done      = 1'b1;
                w_word      = w_shifted;
              end
            end
          end
        end
`ifdef SHIFT_DES_PARITY_EN
        PARITY: begin
          if (bit_valid) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
            w_word      = r_sr;
            w_perr      = r_par ^ bit_in;
          end
        end
`endif
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State, shift register, counter, direction and running parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_lsb   <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lsb   <= w_lsb_nxt;
      r_par   <= w_par_nxt;
    end
  end

  assign busy = (r_state != IDLE);

  shift_des_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_done      (w_done),
    .i_word      (w_word),
    .i_perr      (w_perr),
    .i_ready     (word_ready),
    .i_clear_err (clear_err),
    .o_word      (word_out),
    .o_valid     (word_valid),
    .o_perr      (word_perr),
    .o_overrun   (overrun)
  );

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module     : tb_shift_deserializer                                      |
// | Description: Scoreboard bench for shift_deserializer. Parity cases run  |
// |              when SHIFT_DES_PARITY_EN is defined.                       |
// | Revision   : 1.0 - initial release                                      |
// +-------------------------------------------------------------------------+
module tb_shift_deserializer;

  localparam int WIDTH = 4;
`ifdef SHIFT_DES_PARITY_EN
  localparam int c_FRAME = WIDTH + 1;
`else
  localparam int c_FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             lsb_first = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready = 1'b1;
  logic             word_perr;
  logic             busy;
  logic             overrun;
  logic             clear_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  // Expected {perr, word} in delivery order.
  logic [WIDTH:0] exp_q[$];

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .lsb_first   (lsb_first),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_perr   (word_perr),
    .busy        (busy),
    .overrun     (overrun),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", word_out, $time);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        if ({word_perr, word_out} !== e) begin
          n_fail++;
          $display("FAIL word: got perr=%0b word=%0h expected perr=%0b word=%0h at %0t",
                   word_perr, word_out, e[WIDTH], e[WIDTH-1:0], $time);
        end
      end
    end
  end

  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic lsb);
    frame_start = 1'b1;
    lsb_first   = lsb;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // tx[3] is transmitted first; parity builds append the correct even bit.
  task automatic send_data(input logic [3:0] tx);
    for (int i = 3; i >= 0; i--) send_bit(tx[i]);
`ifdef SHIFT_DES_PARITY_EN
    send_bit(^tx);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #2;
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word", {28'd0, word_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_perr", {31'd0, word_perr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // bit_valid in IDLE is ignored
    send_bit(1'b1);
    tick();
    chk("idle_ignore_busy", {31'd0, busy}, 32'd0);
    chk("idle_ignore_valid", {31'd0, word_valid}, 32'd0);

    // LSB-first 1,0,1,1 -> D, valid exactly one cycle
    start(1'b1);
    exp_q.push_back({1'b0, 4'hD});
    send_data(4'b1011);
    chk("lsb_valid_rise", {31'd0, word_valid}, 32'd1);
    chk("lsb_word", {28'd0, word_out}, 32'hD);
    tick();
    chk("lsb_valid_fall", {31'd0, word_valid}, 32'd0);

    // MSB-first 1,0,1,1 -> B; busy for one frame
    busy_cnt = 0;
    start(1'b0);
    exp_q.push_back({1'b0, 4'hB});
    send_data(4'b1011);
    chk("msb_busy_after", {31'd0, busy}, 32'd0);
    tick();
    chk("msb_busy_cycles", busy_cnt, c_FRAME);

    // Back-to-back: frame_start right after final bit
    start(1'b1);
    exp_q.push_back({1'b0, 4'h3});
    send_data(4'b1100);
    start(1'b0);
    exp_q.push_back({1'b0, 4'hC});
    send_data(4'b1100);
    tick();

    // Overrun: held 5, A dropped
    word_ready = 1'b0;
    start(1'b1);
    exp_q.push_back({1'b0, 4'h5});
    send_data(4'b1010);
    start(1'b1);
    send_data(4'b0101);
    tick();
    tick();
    chk("ovr_word_held", {28'd0, word_out}, 32'h5);
    chk("ovr_valid", {31'd0, word_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    word_ready = 1'b1;
    tick();
    chk("ovr_drained", {31'd0, word_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Abort: partial frame then restart -> single 8
    start(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    start(1'b1);
    exp_q.push_back({1'b0, 4'h8});
    send_data(4'b0001);
    tick();
    chk("abort_no_ovr", {31'd0, overrun}, 32'd0);
    chk("abort_q_empty", exp_q.size(), 32'd0);

    // Async reset mid-frame
    start(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_word", {28'd0, word_out}, 32'd0);
    chk("arst_valid", {31'd0, word_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start(1'b1);
    exp_q.push_back({1'b0, 4'h3});
    send_data(4'b1100);
    chk("post_rst_word", {28'd0, word_out}, 32'h3);

`ifdef SHIFT_DES_PARITY_EN
    // Parity: data 1,1,0,0 with good and bad parity bits
    start(1'b1);
    exp_q.push_back({1'b0, 4'h3});
    for (int i = 3; i >= 0; i--) send_bit(i >= 2);
    send_bit(1'b0);
    chk("par_ok_perr", {31'd0, word_perr}, 32'd0);
    start(1'b1);
    exp_q.push_back({1'b1, 4'h3});
    for (int i = 3; i >= 0; i--) send_bit(i >= 2);
    send_bit(1'b1);
    chk("par_bad_perr", {31'd0, word_perr}, 32'd1);
`else
    chk("perr_tied", {31'd0, word_perr}, 32'd0);
`endif

    tick();
    tick();
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
